// File: rtl/button_autorepeat_if.sv
// Button conditioner bundle: raw button level in, conditioned press events out.
interface button_autorepeat_if;
  logic button_in;
  logic press_pulse;
  logic held;
  logic repeat_active;

  // Button source / event consumer side
  modport master (
    output button_in,
    input  press_pulse,
    input  held,
    input  repeat_active
  );

  // Conditioner side
  modport slave (
    input  button_in,
    output press_pulse,
    output held,
    output repeat_active
  );
endinterface

// File: rtl/button_autorepeat.sv
// Push-button conditioner: 2-flop synchronizer, press/release debounce and
// hold-to-repeat pulse generation, all timed by one shared cycle counter.
module button_autorepeat #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned HOLD_CYCLES     = 25000000,
  parameter int unsigned REPEAT_CYCLES   = 5000000,
  parameter bit          AUTOREPEAT      = 1'b1,
  parameter int unsigned CNT_W           = 25
) (
  input  logic                 clk,
  input  logic                 reset,
  button_autorepeat_if.slave   bus
);

  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    DEB_PRESS   = 3'd1,
    PRESSED     = 3'd2,
    REPEAT      = 3'd3,
    DEB_RELEASE = 3'd4
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             s1, s2;
  logic             btn_s;
  logic             pulse_q, pulse_n;
  logic             held_q, held_n;
  logic             rep_q, rep_n;

  assign btn_s = s2;

  // Two-flop synchronizer for the asynchronous button level
  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= bus.button_in;
      s2 <= s1;
    end
  end

  // State, shared counter and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      pulse_q <= 1'b0;
      held_q  <= 1'b0;
      rep_q   <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      pulse_q <= pulse_n;
      held_q  <= held_n;
      rep_q   <= rep_n;
    end
  end

  // Next-state, counter and output decode; release always beats timer expiry
  always_comb begin
    state_n = state;
    cnt_n   = cnt + CNT_W'(1);
    pulse_n = 1'b0;

    case (state)
      IDLE: begin
        cnt_n = '0;
        if (btn_s) state_n = DEB_PRESS;
      end

      DEB_PRESS: begin
        if (!btn_s) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (cnt == DEB_LAST) begin
          state_n = PRESSED;
          cnt_n   = '0;
          pulse_n = 1'b1;
        end
      end

      PRESSED: begin
        if (!btn_s) begin
          state_n = DEB_RELEASE;
          cnt_n   = '0;
        end else if (cnt == HOLD_LAST) begin
          if (AUTOREPEAT) begin
            state_n = REPEAT;
            cnt_n   = '0;
            pulse_n = 1'b1;
          end else begin
            // Single-shot mode: park the counter at expiry
            cnt_n = cnt;
          end
        end
      end

      REPEAT: begin
        if (!btn_s) begin
          state_n = DEB_RELEASE;
          cnt_n   = '0;
        end else if (cnt == REP_LAST) begin
          cnt_n   = '0;
          pulse_n = 1'b1;
        end
      end

      DEB_RELEASE: begin
        if (btn_s) begin
          // Bounce on release: back to held, hold timer restarts
          state_n = PRESSED;
          cnt_n   = '0;
        end else if (cnt == DEB_LAST) begin
          state_n = IDLE;
          cnt_n   = '0;
        end
      end

      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase

    held_n = (state_n == PRESSED) || (state_n == REPEAT) || (state_n == DEB_RELEASE);
    rep_n  = (state_n == REPEAT);
  end

  assign bus.press_pulse   = pulse_q;
  assign bus.held          = held_q;
  assign bus.repeat_active = rep_q;

endmodule

// File: tb/tb_button_autorepeat.sv
// Directed bench for button_autorepeat (D=4, H=10, R=3). Edge index k counts
// from the edge N at which s1 first captures the button; outputs are sampled
// 1 time unit after each edge, so a value at k is the register value after N+k.
module tb_button_autorepeat;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  button_autorepeat_if bus0();
  button_autorepeat_if bus1();

  button_autorepeat #(
    .DEBOUNCE_CYCLES(4), .HOLD_CYCLES(10), .REPEAT_CYCLES(3),
    .AUTOREPEAT(1'b1), .CNT_W(8)
  ) dut_rep (
    .clk(clk), .reset(reset), .bus(bus0)
  );

  button_autorepeat #(
    .DEBOUNCE_CYCLES(4), .HOLD_CYCLES(10), .REPEAT_CYCLES(3),
    .AUTOREPEAT(1'b0), .CNT_W(8)
  ) dut_once (
    .clk(clk), .reset(reset), .bus(bus1)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus0.button_in = 1'b0;
    bus1.button_in = 1'b0;
    idle(3);
    total++;
    if ({bus0.press_pulse, bus0.held, bus0.repeat_active} !== 3'b000) begin
      bad++;
      $display("FAIL reset_outputs_rep got=%b exp=000",
               {bus0.press_pulse, bus0.held, bus0.repeat_active});
    end
    total++;
    if ({bus1.press_pulse, bus1.held, bus1.repeat_active} !== 3'b000) begin
      bad++;
      $display("FAIL reset_outputs_once got=%b exp=000",
               {bus1.press_pulse, bus1.held, bus1.repeat_active});
    end
    reset = 1'b0;
    idle(4);
  endtask

  // Button high for 3 captures: debounce never completes
  task automatic test_glitch();
    int npulse = 0;
    int nheld  = 0;
    int nrep   = 0;
    bus0.button_in = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (bus0.press_pulse)   npulse++;
      if (bus0.held)          nheld++;
      if (bus0.repeat_active) nrep++;
      bus0.button_in = ((k + 1) < 3);
    end
    total++;
    if (npulse !== 0) begin bad++; $display("FAIL glitch_pulses got=%0d exp=0", npulse); end
    total++;
    if (nheld !== 0) begin bad++; $display("FAIL glitch_held got=%0d exp=0", nheld); end
    total++;
    if (nrep !== 0) begin bad++; $display("FAIL glitch_repeat got=%0d exp=0", nrep); end
  endtask

  // 9 captures high: one pulse at N+6, DEB_RELEASE from N+11, IDLE at N+15
  task automatic test_short_press();
    int   pulses[$];
    logic hv[32];
    int   nrep = 0;
    bus0.button_in = 1'b1;
    for (int k = 0; k < 24; k++) begin
      tick();
      if (bus0.press_pulse) pulses.push_back(k);
      if (bus0.repeat_active) nrep++;
      hv[k] = bus0.held;
      bus0.button_in = ((k + 1) < 9);
    end
    total++;
    if (pulses.size() !== 1) begin bad++; $display("FAIL short_pulse_count got=%0d exp=1", pulses.size()); end
    total++;
    if ((pulses.size() > 0 ? pulses[0] : -1) !== 6) begin
      bad++; $display("FAIL short_pulse_edge got=%0d exp=6", (pulses.size() > 0 ? pulses[0] : -1));
    end
    total++;
    if ({hv[5], hv[6], hv[14], hv[15]} !== 4'b0110) begin
      bad++; $display("FAIL short_held_profile got=%b exp=0110", {hv[5], hv[6], hv[14], hv[15]});
    end
    total++;
    if (nrep !== 0) begin bad++; $display("FAIL short_repeat got=%0d exp=0", nrep); end
  endtask

  // 29 captures high: pulses 6,16,19,22,25,28; release at N+31 beats the
  // repeat expiry that would have fired there
  task automatic test_long_hold();
    int   pulses[$];
    int   exp_p[6] = '{6, 16, 19, 22, 25, 28};
    logic hv[48];
    logic rv[48];
    int   got;
    bus0.button_in = 1'b1;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (bus0.press_pulse) pulses.push_back(k);
      hv[k] = bus0.held;
      rv[k] = bus0.repeat_active;
      bus0.button_in = ((k + 1) < 29);
    end
    total++;
    if (pulses.size() !== 6) begin bad++; $display("FAIL long_pulse_count got=%0d exp=6", pulses.size()); end
    for (int i = 0; i < 6; i++) begin
      got = (i < pulses.size()) ? pulses[i] : -1;
      total++;
      if (got !== exp_p[i]) begin
        bad++; $display("FAIL long_pulse_edge[%0d] got=%0d exp=%0d", i, got, exp_p[i]);
      end
    end
    total++;
    if ({rv[15], rv[16], rv[30], rv[31]} !== 4'b0110) begin
      bad++; $display("FAIL long_repeat_profile got=%b exp=0110", {rv[15], rv[16], rv[30], rv[31]});
    end
    total++;
    if ({hv[34], hv[35]} !== 2'b10) begin
      bad++; $display("FAIL long_held_release got=%b exp=10", {hv[34], hv[35]});
    end
  endtask

  // Release with a one-capture blip at N+11: PRESSED again at N+13, final
  // DEB_RELEASE at N+14, IDLE at N+18, no extra pulse
  task automatic test_release_bounce();
    int   pulses[$];
    logic hv[32];
    int   nlow = 0;
    int   nrep = 0;
    bus0.button_in = 1'b1;
    for (int k = 0; k < 26; k++) begin
      tick();
      if (bus0.press_pulse) pulses.push_back(k);
      if (bus0.repeat_active) nrep++;
      hv[k] = bus0.held;
      if (k >= 6 && k <= 17 && !bus0.held) nlow++;
      bus0.button_in = ((k + 1) < 9) || ((k + 1) == 11);
    end
    total++;
    if (pulses.size() !== 1) begin bad++; $display("FAIL bounce_pulse_count got=%0d exp=1", pulses.size()); end
    total++;
    if (nlow !== 0) begin bad++; $display("FAIL bounce_held_drop got=%0d exp=0", nlow); end
    total++;
    if ({hv[5], hv[17], hv[18]} !== 3'b010) begin
      bad++; $display("FAIL bounce_held_profile got=%b exp=010", {hv[5], hv[17], hv[18]});
    end
    total++;
    if (nrep !== 0) begin bad++; $display("FAIL bounce_repeat got=%0d exp=0", nrep); end
  endtask

  // Reset for one edge (N+21) while in REPEAT; first low-reset edge R=N+22
  // recaptures the held button, so the new pulse lands at R+6=N+28
  task automatic test_reset_in_repeat();
    int   pulses[$];
    int   exp_p[4] = '{6, 16, 19, 28};
    int   got;
    logic rep20 = 1'b0;
    logic held45;
    bus0.button_in = 1'b1;
    for (int k = 0; k < 46; k++) begin
      tick();
      if (bus0.press_pulse) pulses.push_back(k);
      if (k == 20) begin
        rep20 = bus0.repeat_active;
        reset = 1'b1;
      end
      if (k == 21) begin
        total++;
        if ({bus0.press_pulse, bus0.held, bus0.repeat_active} !== 3'b000) begin
          bad++; $display("FAIL rst_repeat_outputs got=%b exp=000",
                          {bus0.press_pulse, bus0.held, bus0.repeat_active});
        end
        reset = 1'b0;
      end
      bus0.button_in = ((k + 1) < 34);
    end
    held45 = bus0.held;
    total++;
    if (rep20 !== 1'b1) begin bad++; $display("FAIL rst_was_repeat got=%b exp=1", rep20); end
    total++;
    if (pulses.size() !== 4) begin bad++; $display("FAIL rst_pulse_count got=%0d exp=4", pulses.size()); end
    for (int i = 0; i < 4; i++) begin
      got = (i < pulses.size()) ? pulses[i] : -1;
      total++;
      if (got !== exp_p[i]) begin
        bad++; $display("FAIL rst_pulse_edge[%0d] got=%0d exp=%0d", i, got, exp_p[i]);
      end
    end
    total++;
    if (held45 !== 1'b0) begin bad++; $display("FAIL rst_final_held got=%b exp=0", held45); end
  endtask

  // Single-shot instance held 30 captures: one pulse, stays PRESSED past
  // hold expiry, DEB_RELEASE at N+32, IDLE at N+36
  task automatic test_no_autorepeat();
    int   pulses[$];
    logic hv[48];
    int   nrep = 0;
    bus1.button_in = 1'b1;
    for (int k = 0; k < 42; k++) begin
      tick();
      if (bus1.press_pulse) pulses.push_back(k);
      if (bus1.repeat_active) nrep++;
      hv[k] = bus1.held;
      bus1.button_in = ((k + 1) < 30);
    end
    total++;
    if (pulses.size() !== 1) begin bad++; $display("FAIL once_pulse_count got=%0d exp=1", pulses.size()); end
    total++;
    if ((pulses.size() > 0 ? pulses[0] : -1) !== 6) begin
      bad++; $display("FAIL once_pulse_edge got=%0d exp=6", (pulses.size() > 0 ? pulses[0] : -1));
    end
    total++;
    if (nrep !== 0) begin bad++; $display("FAIL once_repeat got=%0d exp=0", nrep); end
    total++;
    if ({hv[31], hv[35], hv[36]} !== 3'b110) begin
      bad++; $display("FAIL once_held_profile got=%b exp=110", {hv[31], hv[35], hv[36]});
    end
  endtask

  initial begin
    test_reset();
    test_glitch();
    idle(3);
    test_short_press();
    idle(3);
    test_long_hold();
    idle(3);
    test_release_bounce();
    idle(3);
    test_reset_in_repeat();
    idle(3);
    test_no_autorepeat();
    idle(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
